piso_shift_ctrl: RTL

- Sequencer for the team's 4-bit parallel-in/serial-out shift register.
- Accepts parallel words on a valid/ready handshake and holds one word in a single-entry buffer.
- Drives the PISO mode line (s_lbar: 0 = load, 1 = shift) and the PISO parallel input.
- Flags each serial bit with valid, index and last markers; back-to-back words stream with no gap cycles.

---
 rtl/piso_ctrl_pkg.sv | 15 +
 rtl/piso_hold_reg.sv | 35 +++
 rtl/piso_shift_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/piso_ctrl_pkg.sv
// Shared types and encodings for the PISO sequencer.
package piso_ctrl_pkg;

   // Sequencer states: idle, one-cycle parallel load, WIDTH-cycle shift.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   // PISO mode-line encoding (s_lbar).
   localparam logic S_LOAD  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

endpackage : piso_ctrl_pkg

// File: rtl/piso_hold_reg.sv
// Single-entry word buffer between the input handshake and the PISO load.
// A fill always wins over a consume; the controller never asserts both
// because it only fills while the buffer is empty.
module piso_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_fill,
   input  logic             i_consume,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // Buffer storage: synchronous clear, capture on fill, release on consume.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_full <= 1'b0;
         r_data <= {WIDTH{1'b0}};
      end else if (i_fill) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_consume) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule : piso_hold_reg

// File: rtl/piso_shift_ctrl.sv
// Sequencer for a parallel-in/serial-out shift register: buffers one word,
// drives the PISO load/shift line and parallel input, and tags each serial
// bit with valid, index and last markers. Words stream back to back when
// the next word is already buffered by the final bit of the current one.
module piso_shift_ctrl
   import piso_ctrl_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             s_lbar,
   output logic [WIDTH-1:0] pdata,
   input  logic             q_in,
   output logic             ser_valid,
   output logic             ser_data,
   output logic [IDXW-1:0]  bit_idx,
   output logic             last_bit,
   output logic             busy
);

   localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDXW-1:0]   r_idx;
   logic [IDXW-1:0]   w_idx_nxt;
   logic              w_hold_full;
   logic [WIDTH-1:0]  w_hold_data;
   logic              w_fill;
   logic              w_consume;
   logic              w_s_lbar;
   logic              w_ser_valid;
   logic              w_idx_last;

   // The buffer only accepts while empty, so fill and consume never collide.
   assign w_fill     = in_valid && !w_hold_full;
   assign w_idx_last = (r_idx == IDX_LAST);

   piso_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .i_clr     (rst),
      .i_fill    (w_fill),
      .i_consume (w_consume),
      .i_data    (in_data),
      .o_full    (w_hold_full),
      .o_data    (w_hold_data)
   );

   // State and bit-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= IDX_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state, bit index, buffer consume and PISO mode decode.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_consume   = 1'b0;
      w_s_lbar    = S_SHIFT;
      w_ser_valid = 1'b0;
      case (r_state)
         IDLE: begin
            // A word landing on this edge goes straight to LOAD next cycle.
            w_idx_nxt = IDX_ZERO;
            if (w_hold_full || w_fill) begin
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD: begin
            w_s_lbar    = S_LOAD;
            w_consume   = 1'b1;
            w_idx_nxt   = IDX_ZERO;
            w_state_nxt = SHIFT;
         end
         SHIFT: begin
            w_ser_valid = 1'b1;
            if (w_idx_last) begin
               w_idx_nxt = IDX_ZERO;
               if (w_hold_full) begin
                  // Reload on the final bit so the next word follows gap-free.
                  w_s_lbar    = S_LOAD;
                  w_consume   = 1'b1;
                  w_state_nxt = SHIFT;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_idx_nxt   = r_idx + IDX_ONE;
               w_state_nxt = SHIFT;
            end
         end
         default: begin
            w_idx_nxt   = IDX_ZERO;
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = !w_hold_full;
   assign s_lbar    = w_s_lbar;
   assign pdata     = (w_s_lbar == S_LOAD) ? w_hold_data : {WIDTH{1'b0}};
   assign ser_valid = w_ser_valid;
   assign ser_data  = q_in & w_ser_valid;
   assign bit_idx   = r_idx;
   assign last_bit  = w_ser_valid && w_idx_last;
   assign busy      = (r_state != IDLE) || w_hold_full;

endmodule : piso_shift_ctrl
